lcd_rd_ctrl: RTL and testbench
==============================

Name: lcd_rd_ctrl

Overview:
Read-side engine for the 8080-style LCD parallel bus; the existing LCD write path drives LCD_WR, LCD_RS and LCD_RST.
- Accepts a read request (RS level, word count, optional dummy read) from the APB LCD register block.
- Generates CS#/RS/RD# timing and samples the data bus at the RD# rising edge.
- Returns words through a valid/ready stream.
- Arbitrates the shared bus against the write path.

Parameters:
DW, 16, LCD data bus width
T_SETUP, 1, clk cycles RS/CS# valid before RD# falls (min 1)
T_RDL, 4, clk cycles RD# held low (min 1)
T_RDH, 2, clk cycles RD# held high between words (min 1)
CNT_W, 8, width of word count

Ports:
clk  in  1  system clock
resetn  in  1  async active-low reset
req_valid  in  1  read request
req_ready  out  1  request accepted when valid&ready
req_rs  in  1  RS level for the transaction (0=cmd/status, 1=data)
req_num  in  CNT_W  words to return; 0 = no bus cycle
req_dummy  in  1  perform and discard one leading dummy read
wr_busy  in  1  write path owns the bus
rsp_valid  out  1  read word available
rsp_ready  in  1  consumer accepts word
rsp_data  out  DW  sampled word
rsp_last  out  1  final word of transaction
done  out  1  one-cycle pulse at transaction end
busy  out  1  bus owned by reader (state != IDLE)
lcd_cs_n  out  1  chip select
lcd_rs  out  1  register select
lcd_rd_n  out  1  read strobe
lcd_db_oe  out  1  0 while reader owns bus (tristate DB)
lcd_db_i  in  DW  data bus input

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_last=0, done=0, busy=0.
  - lcd_cs_n=1, lcd_rs=1, lcd_rd_n=1, lcd_db_oe=1.
  - State IDLE; counters 0.
- Handshake:
  - req_ready = (state==IDLE) & ~wr_busy.
  - On accept, latch rs, num, dummy.
  - Total reads = num + dummy.
  - num==0 with dummy=0: no bus activity; done pulses the next cycle; state returns to IDLE.
  - num==0 with dummy=1: one dummy cycle, no rsp, then done.
- States:
  - IDLE
  - SETUP: cs_n=0, rs=latched, db_oe=0, rd_n=1; T_SETUP cycles.
  - RDL: rd_n=0; T_RDL cycles.
  - SAMPLE: one cycle.
    - rd_n returns to 1.
    - lcd_db_i is registered on entry, i.e. the value present in the last RDL cycle.
    - A dummy word is discarded; otherwise the word goes to the rsp register.
  - HOLD: entered if rsp_valid is still set when a new word must be presented; rd_n stays 1.
  - RDH: rd_n=1 for T_RDH cycles, then SETUP is skipped and the next word goes directly to RDL.
  - DONE: cs_n=1, db_oe=1, done=1 for one cycle, then IDLE.
- Response path:
  - Single-entry output register.
  - rsp_valid stays high until rsp_ready.
  - rsp_data and rsp_last are stable while valid & ~ready.
  - rsp_last=1 on word index num-1.
- Flow control: the next RD# falling edge is never issued while the output register is full and unaccepted. RDH completes, then HOLD waits. No word is ever dropped.
- Transaction end: after the last word's RDH, go to DONE. done asserts only after the last rsp has been accepted (wait in HOLD if needed).
- wr_busy:
  - Sampled only in IDLE.
  - Once the reader leaves IDLE, it owns the bus until DONE.
  - wr_busy asserted mid-transaction is ignored.
- Word counter: CNT_W+1 bits, so num=2^CNT_W-1 with dummy does not wrap.
- Reset mid-transaction: immediately returns every output to its reset value. A partial word is not emitted.
- Latency, request accept to first rsp_valid (rsp_ready=1, no dummy): T_SETUP+T_RDL+1 cycles.
- Per-word period: T_RDL+1+T_RDH cycles.

Decomposition:
- Shared package lcd_pkg:
  - State enum.
  - DW default.
  - Timing defaults T_SETUP/T_RDL/T_RDH.
  - The write path uses the same constants.
- Sub-module lcd_tcnt: loadable down-counter with zero flag, reused for the SETUP/RDL/RDH phases.
- Everything else lives in lcd_rd_ctrl.

Test Plan:
1. Basic read:
   - Stimulus: req_rs=1, num=3, dummy=0, rsp_ready=1, lcd_db_i changes to 0x1111/0x2222/0x3333 during each RDL.
   - Response: rsp words 0x1111, 0x2222, 0x3333; rsp_last on the third; rd_n low exactly 4 cycles each; done one cycle after the last RDH.
2. Dummy read:
   - Stimulus: rs=0, num=1, dummy=1, bus values 0xDEAD then 0x9341.
   - Response: a single rsp 0x9341 with last=1; two RD# pulses.
3. Backpressure:
   - Stimulus: num=2, rsp_ready=0 for 20 cycles after the first valid.
   - Response: rsp_data holds word0; no second RD# falling edge until accept; word1 delivered; no loss.
4. Zero length:
   - Stimulus: num=0, dummy=0.
   - Response: no RD# pulse; cs_n stays 1; done pulses once; req_ready high again 2 cycles later.
5. Arbitration:
   - Stimulus: wr_busy=1 while req_valid=1.
   - Response: req_ready=0 and bus idle. When wr_busy drops: accept next cycle. wr_busy raised mid-read: transaction completes.
6. Reset mid-operation:
   - Stimulus: resetn=0 during RDL of word 2 of 4.
   - Response: rd_n=1, cs_n=1, db_oe=1, rsp_valid=0 asynchronously. After release, a new num=1 request works normally.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants for the 8080-style LCD bus engines (read and write paths).
// State codes stay plain constants so existing write-path code can share them.
package lcd_pkg;

    localparam int unsigned LCD_DW      = 16;
    localparam int unsigned LCD_T_SETUP = 1;
    localparam int unsigned LCD_T_RDL   = 4;
    localparam int unsigned LCD_T_RDH   = 2;
    localparam int unsigned LCD_CNT_W   = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_RDL    = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_RDH    = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    function automatic int unsigned lcd_max3(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_tcnt.sv
// Loadable down-counter with zero flag; times the SETUP/RDL/RDH bus phases.
// A phase of N cycles loads N-1 on entry and ends in the cycle zero is high.
module lcd_tcnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_rd_ctrl.sv
// Read-side engine for the 8080 LCD bus: CS#/RS/RD# sequencing, bus sampling
// at the RD# rising edge, and a single-entry valid/ready response register.
module lcd_rd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned DW      = LCD_DW,
    parameter int unsigned T_SETUP = LCD_T_SETUP,
    parameter int unsigned T_RDL   = LCD_T_RDL,
    parameter int unsigned T_RDH   = LCD_T_RDH,
    parameter int unsigned CNT_W   = LCD_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rs,
    input  logic [CNT_W-1:0] req_num,
    input  logic             req_dummy,
    input  logic             wr_busy,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_data,
    output logic             rsp_last,
    output logic             done,
    output logic             busy,
    output logic             lcd_cs_n,
    output logic             lcd_rs,
    output logic             lcd_rd_n,
    output logic             lcd_db_oe,
    input  logic [DW-1:0]    lcd_db_i
);

    localparam int unsigned TMAX = lcd_max3(T_SETUP, T_RDL, T_RDH);
    localparam int unsigned TW   = $clog2(TMAX + 1);

    logic [2:0]     state, state_nxt;
    logic           rs_q;
    logic           dummy_q;
    logic [CNT_W:0] rd_left;
    logic           t_load;
    logic [TW-1:0]  t_val;
    logic           t_zero;
    logic           accept;
    logic           blocked;
    logic           capture;
    logic           bus_own;

    assign req_ready = resetn && (state == ST_IDLE) && !wr_busy;
    assign accept    = req_valid && req_ready;
    assign blocked   = rsp_valid && !rsp_ready;
    assign capture   = (state == ST_RDL) && t_zero;

    lcd_tcnt #(
        .W (TW)
    ) u_tcnt (
        .clk      (clk),
        .resetn   (resetn),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    // RDH and HOLD share the decision: RD# may only fall again once the
    // response register is free, and DONE waits until the last word is taken.
    always_comb begin
        state_nxt = state;
        t_load    = 1'b0;
        t_val     = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if ((req_num == '0) && !req_dummy) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_SETUP;
                        t_load    = 1'b1;
                        t_val     = TW'(T_SETUP - 1);
                    end
                end
            end
            ST_SETUP: begin
                if (t_zero) begin
                    if (blocked) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        state_nxt = ST_RDL;
                        t_load    = 1'b1;
                        t_val     = TW'(T_RDL - 1);
                    end
                end
            end
            ST_RDL: begin
                if (t_zero) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                state_nxt = ST_RDH;
                t_load    = 1'b1;
                t_val     = TW'(T_RDH - 1);
            end
            ST_RDH, ST_HOLD: begin
                if ((state == ST_HOLD) || t_zero) begin
                    if (blocked) begin
                        state_nxt = ST_HOLD;
                    end else if (rd_left == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_RDL;
                        t_load    = 1'b1;
                        t_val     = TW'(T_RDL - 1);
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            rs_q    <= 1'b1;
            dummy_q <= 1'b0;
            rd_left <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rs_q    <= req_rs;
                dummy_q <= req_dummy;
                rd_left <= {1'b0, req_num} + {{CNT_W{1'b0}}, req_dummy};
            end else if (capture) begin
                rd_left <= rd_left - 1'b1;
                dummy_q <= 1'b0;
            end
        end
    end

    // The register is always empty at capture time because RDL is only
    // entered when it is free or being accepted in that same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
        end else if (capture && !dummy_q) begin
            rsp_valid <= 1'b1;
            rsp_data  <= lcd_db_i;
            rsp_last  <= (rd_left == (CNT_W+1)'(1));
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign bus_own   = (state == ST_SETUP) || (state == ST_RDL) ||
                       (state == ST_SAMPLE) || (state == ST_HOLD) ||
                       (state == ST_RDH);
    assign lcd_cs_n  = !bus_own;
    assign lcd_db_oe = !bus_own;
    assign lcd_rd_n  = (state != ST_RDL);
    assign lcd_rs    = rs_q;
    assign done      = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_rd_ctrl.sv
// Directed bench for lcd_rd_ctrl: a bus model answers each RD# pulse from a
// table and a monitor collects accepted response words.
module tb_lcd_rd_ctrl;

    localparam int unsigned T_RDL = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_rs, req_dummy, wr_busy, rsp_ready;
    logic [7:0]  req_num;
    logic        req_ready, rsp_valid, rsp_last, done, busy;
    logic        lcd_cs_n, lcd_rs, lcd_rd_n, lcd_db_oe;
    logic [15:0] rsp_data;
    logic [15:0] lcd_db_i;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          fall_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          cs_low_cnt = 0;
    int          first_v_cyc = -1;
    int          low_len = 0;
    logic        rd_prev = 1'b1;
    logic        rs_at_fall = 1'b0;
    logic        oe_at_fall = 1'b1;
    logic [15:0] bus_tab [32];
    logic [16:0] rq [$];

    lcd_rd_ctrl #(
        .DW      (16),
        .T_SETUP (1),
        .T_RDL   (4),
        .T_RDH   (2),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs    (req_rs),
        .req_num   (req_num),
        .req_dummy (req_dummy),
        .wr_busy   (wr_busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .done      (done),
        .busy      (busy),
        .lcd_cs_n  (lcd_cs_n),
        .lcd_rs    (lcd_rs),
        .lcd_rd_n  (lcd_rd_n),
        .lcd_db_oe (lcd_db_oe),
        .lcd_db_i  (lcd_db_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus model and monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!lcd_rd_n) begin
            if (rd_prev) begin
                lcd_db_i   = bus_tab[fall_cnt];
                fall_cnt   = fall_cnt + 1;
                rs_at_fall = lcd_rs;
                oe_at_fall = lcd_db_oe;
            end
            low_len = low_len + 1;
        end else begin
            if (!rd_prev && resetn) chk("rdl_width", low_len, T_RDL);
            low_len = 0;
        end
        rd_prev = lcd_rd_n;
        if (!lcd_cs_n) cs_low_cnt = cs_low_cnt + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (rsp_valid && first_v_cyc < 0) first_v_cyc = cyc;
        if (rsp_valid && rsp_ready && resetn) rq.push_back({rsp_last, rsp_data});
    end

    task automatic send_req(input logic rs, input logic [7:0] num, input logic dummy);
        int n;
        req_rs = rs; req_num = num; req_dummy = dummy; req_valid = 1'b1;
        first_v_cyc = -1;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        chk("req_accept", (n < 50), 1);
        tick();
        req_valid = 1'b0;
        acc_cyc = cyc - 1;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 300) begin tick(); n++; end
        chk("done_seen", (done_cnt != d0), 1);
        tick();
    endtask

    task automatic chk_rsp(input string tag, input int idx, input logic [15:0] d, input logic l);
        logic [16:0] got;
        got = (idx < rq.size()) ? rq[idx] : 17'h1_FFFF;
        chk(tag, got, {l, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, d0, cs0, bad, n;
        resetn = 1'b0; req_valid = 1'b0; req_rs = 1'b0; req_num = '0;
        req_dummy = 1'b0; wr_busy = 1'b0; rsp_ready = 1'b1; lcd_db_i = '0;
        for (int i = 0; i < 32; i++) bus_tab[i] = 16'hBAD0 + 16'(i);
        #23;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data",  rsp_data, 0);
        chk("rst_rsp_last",  rsp_last, 0);
        chk("rst_done",      done, 0);
        chk("rst_busy",      busy, 0);
        chk("rst_bus", {lcd_cs_n, lcd_rs, lcd_rd_n, lcd_db_oe}, 4'b1111);
        tick(); resetn = 1'b1; tick();
        chk("idle_ready", req_ready, 1);

        // 1: basic read, three words
        base = fall_cnt; d0 = done_cnt; rq.delete();
        bus_tab[base] = 16'h1111; bus_tab[base+1] = 16'h2222; bus_tab[base+2] = 16'h3333;
        send_req(1'b1, 8'd3, 1'b0);
        wait_done(d0);
        chk("t1_latency", first_v_cyc - acc_cyc, 6);
        chk("t1_done_cyc", done_cyc - acc_cyc, 23);
        chk("t1_pulses", fall_cnt - base, 3);
        chk("t1_rs_oe", {rs_at_fall, oe_at_fall}, 2'b10);
        chk("t1_nrsp", rq.size(), 3);
        chk_rsp("t1_w0", 0, 16'h1111, 1'b0);
        chk_rsp("t1_w1", 1, 16'h2222, 1'b0);
        chk_rsp("t1_w2", 2, 16'h3333, 1'b1);
        chk("t1_done_once", done_cnt - d0, 1);

        // 2: dummy read, rs=0
        base = fall_cnt; d0 = done_cnt; rq.delete();
        bus_tab[base] = 16'hDEAD; bus_tab[base+1] = 16'h9341;
        send_req(1'b0, 8'd1, 1'b1);
        wait_done(d0);
        chk("t2_pulses", fall_cnt - base, 2);
        chk("t2_rs", rs_at_fall, 0);
        chk("t2_nrsp", rq.size(), 1);
        chk_rsp("t2_w0", 0, 16'h9341, 1'b1);
        chk("t2_latency", first_v_cyc - acc_cyc, 13);
        chk("t2_done_cyc", done_cyc - acc_cyc, 16);

        // 3: backpressure
        base = fall_cnt; d0 = done_cnt; rq.delete();
        bus_tab[base] = 16'hA5A5; bus_tab[base+1] = 16'h5A5A;
        rsp_ready = 1'b0;
        send_req(1'b1, 8'd2, 1'b0);
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        chk("t3_valid_seen", rsp_valid, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!rsp_valid || rsp_data !== 16'hA5A5 || rsp_last !== 1'b0) bad++;
        end
        chk("t3_stable", bad, 0);
        chk("t3_no_2nd_rd", fall_cnt - base, 1);
        chk("t3_hold_bus", {busy, lcd_rd_n, lcd_cs_n, done}, 4'b1100);
        rsp_ready = 1'b1;
        wait_done(d0);
        chk("t3_pulses", fall_cnt - base, 2);
        chk("t3_nrsp", rq.size(), 2);
        chk_rsp("t3_w0", 0, 16'hA5A5, 1'b0);
        chk_rsp("t3_w1", 1, 16'h5A5A, 1'b1);

        // 4: zero length
        base = fall_cnt; d0 = done_cnt; cs0 = cs_low_cnt; rq.delete();
        send_req(1'b1, 8'd0, 1'b0);
        chk("t4_c1_ready", {req_ready, done}, 2'b01);
        tick();
        chk("t4_c2_ready", {req_ready, done}, 2'b10);
        tick();
        chk("t4_done_cyc", done_cyc - acc_cyc, 1);
        chk("t4_done_once", done_cnt - d0, 1);
        chk("t4_no_rd", fall_cnt - base, 0);
        chk("t4_no_cs", cs_low_cnt - cs0, 0);
        chk("t4_nrsp", rq.size(), 0);

        // 5: arbitration against the write path
        base = fall_cnt; d0 = done_cnt; rq.delete();
        bus_tab[base] = 16'h0F0F;
        wr_busy = 1'b1; req_rs = 1'b1; req_num = 8'd1; req_dummy = 1'b0; req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (req_ready || busy || !lcd_cs_n || !lcd_db_oe) bad++;
        end
        chk("t5_blocked", bad, 0);
        wr_busy = 1'b0;
        #1;
        chk("t5_ready_now", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("t5_accepted", busy, 1);
        tick(); tick();
        wr_busy = 1'b1;
        wait_done(d0);
        chk("t5_nrsp", rq.size(), 1);
        chk_rsp("t5_w0", 0, 16'h0F0F, 1'b1);
        chk("t5_ready_wrbusy", req_ready, 0);
        wr_busy = 1'b0;
        tick();

        // 6: reset during RDL of the second of four words
        base = fall_cnt; rq.delete();
        for (int i = 0; i < 4; i++) bus_tab[base+i] = 16'h00C1 + 16'(i);
        send_req(1'b1, 8'd4, 1'b0);
        n = 0;
        while (!((fall_cnt - base == 2) && !lcd_rd_n) && n < 100) begin tick(); n++; end
        chk("t6_in_rdl2", (n < 100), 1);
        chk("t6_rsp_pre", rsp_data, 16'h00C1);
        resetn = 1'b0;
        #1;
        chk("t6_rst_bus", {lcd_cs_n, lcd_rd_n, lcd_db_oe}, 3'b111);
        chk("t6_rst_rsp", {rsp_valid, rsp_last, busy, done, req_ready}, 5'b0);
        chk("t6_rst_data", rsp_data, 0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        base = fall_cnt; d0 = done_cnt; rq.delete();
        bus_tab[base] = 16'h7777;
        send_req(1'b1, 8'd1, 1'b0);
        wait_done(d0);
        chk("t6_pulses", fall_cnt - base, 1);
        chk("t6_nrsp", rq.size(), 1);
        chk_rsp("t6_w0", 0, 16'h7777, 1'b1);
        chk("t6_latency", first_v_cyc - acc_cyc, 6);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
